// File: rtl/exp_pulse_gen_p.sv
// exp_pulse_gen_p: periodic, exponentially decaying test pulse on a live
// baseline, with an optional second pulse (B) overlaid a programmable number
// of cycles after the main pulse (A). Feeds the filter-bank input samples.
module exp_pulse_gen_p #(
    parameter int DATA_W    = 12,
    parameter int PERIOD_W  = 16,
    parameter int DELAY_W   = 8,
    parameter int TAU_SHIFT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                overlay,
    input  logic [PERIOD_W-1:0] period,
    input  logic [DELAY_W-1:0]  delay,
    input  logic [DATA_W-1:0]   amplitude,
    input  logic [DATA_W-1:0]   baseline,
    output logic [DATA_W-1:0]   output_data,
    output logic                trigger,
    output logic                busy
);
    // Two guard bits so baseline + two full-scale tails can never wrap.
    localparam int SUM_W = DATA_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        WAIT_B = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PERIOD_W-1:0] cnt;
    logic [DELAY_W-1:0]  dcnt;
    logic [DATA_W-1:0]   acc_a;
    logic [DATA_W-1:0]   acc_b;
    logic [DATA_W-1:0]   amp_l;
    logic                vld_p0;

    logic                active;
    logic                fire_a;
    logic                fire_b;
    logic                b_same;
    logic                b_later;
    logic [SUM_W-1:0]    sum_p0;

    // One decay step; the minimum step of 1 guarantees small tails reach zero.
    function automatic logic [DATA_W-1:0] decay_step(input logic [DATA_W-1:0] acc);
        logic [DATA_W-1:0] step;
        step = acc >> TAU_SHIFT;
        if (step == '0) begin
            step = DATA_W'(1);
        end
        return (acc == '0) ? '0 : acc - step;
    endfunction

    // Clamp the widened sum to full-scale code.
    function automatic logic [DATA_W-1:0] sat_sum(input logic [SUM_W-1:0] sum);
        return (|sum[SUM_W-1:DATA_W]) ? '1 : sum[DATA_W-1:0];
    endfunction

    assign active  = enable && (period != '0);
    assign fire_a  = active && (state != IDLE) && (cnt == '0);
    // A has priority: a new A drops a B that would land on the same edge.
    assign fire_b  = active && (state == WAIT_B) && !fire_a && (dcnt == DELAY_W'(1));
    assign b_same  = fire_a && overlay && (delay == '0);
    assign b_later = overlay && (delay != '0);
    assign sum_p0  = SUM_W'(baseline) + SUM_W'(acc_a) + SUM_W'(acc_b);
    assign busy    = (state == WAIT_B) || (acc_a != '0) || (acc_b != '0);

    // Next-state logic: losing enable/period always returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (!active) begin
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            state_nxt = RUN;
        end else if (fire_a) begin
            state_nxt = b_later ? WAIT_B : RUN;
        end else if (fire_b) begin
            state_nxt = RUN;
        end
    end

    // Control: FSM state, period/delay counters and the A-fire strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dcnt    <= '0;
            vld_p0  <= 1'b0;
            trigger <= 1'b0;
        end else begin
            state   <= state_nxt;
            vld_p0  <= fire_a;
            trigger <= vld_p0;
            if (!active || (state == IDLE)) begin
                cnt  <= '0;
                dcnt <= '0;
            end else begin
                cnt <= fire_a ? (period - PERIOD_W'(1)) : (cnt - PERIOD_W'(1));
                if (fire_a) begin
                    if (overlay) begin
                        dcnt <= delay;
                    end
                end else if (state == WAIT_B) begin
                    dcnt <= dcnt - DELAY_W'(1);
                end
            end
        end
    end

    // Datapath: accumulator load/decay (p0), then saturated output sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_a       <= '0;
            acc_b       <= '0;
            amp_l       <= '0;
            output_data <= '0;
        end else begin
            acc_a <= fire_a ? amplitude : decay_step(acc_a);
            if (b_same) begin
                acc_b <= amplitude;
            end else if (fire_b) begin
                acc_b <= amp_l;
            end else begin
                acc_b <= decay_step(acc_b);
            end
            if (fire_a) begin
                amp_l <= amplitude;
            end
            // p0 -> output stage
            output_data <= sat_sum(sum_p0);
        end
    end

endmodule

// File: tb/tb_exp_pulse_gen_p.sv
// Testbench for exp_pulse_gen_p: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a timeline model.
module tb_exp_pulse_gen_p;
    localparam int DATA_W   = 12;
    localparam int PERIOD_W = 16;
    localparam int DELAY_W  = 8;
    localparam int TAU      = 4;
    localparam int FULL     = (1 << DATA_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                overlay;
    logic [PERIOD_W-1:0] period;
    logic [DELAY_W-1:0]  delay;
    logic [DATA_W-1:0]   amplitude;
    logic [DATA_W-1:0]   baseline;
    logic [DATA_W-1:0]   output_data;
    logic                trigger;
    logic                busy;

    int checks = 0;
    int errors = 0;

    exp_pulse_gen_p #(
        .DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .DELAY_W(DELAY_W), .TAU_SHIFT(TAU)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .overlay(overlay),
        .period(period), .delay(delay), .amplitude(amplitude), .baseline(baseline),
        .output_data(output_data), .trigger(trigger), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Pulses are scheduled on an absolute cycle axis: A at next_a, B at b_due.
    longint cyc = 0;
    bit     running = 0;
    longint next_a = 0;
    longint b_due = -1;
    int     m_acc_a = 0, m_acc_b = 0, m_amp_l = 0;
    bit     m_fired = 0;
    int     exp_out = 0;
    bit     exp_trig = 0, exp_busy = 0;

    function automatic int m_decay(input int a);
        int s;
        if (a == 0) return 0;
        s = a >> TAU;
        if (s < 1) s = 1;
        return a - s;
    endfunction

    task automatic m_step();
        int  na, nb;
        bit  fired;
        int  sum;
        sum = int'(baseline) + m_acc_a + m_acc_b;
        exp_out  = (sum > FULL) ? FULL : sum;
        exp_trig = m_fired;
        fired = 0;
        na = m_decay(m_acc_a);
        nb = m_decay(m_acc_b);
        if (!(enable && period != 0)) begin
            running = 0;
            b_due = -1;
        end else if (!running) begin
            running = 1;
            next_a = cyc + 1;
        end else if (cyc == next_a) begin
            fired = 1;
            na = amplitude;
            m_amp_l = amplitude;
            next_a = cyc + period;
            b_due = -1;
            if (overlay) begin
                if (delay == 0) nb = amplitude;
                else b_due = cyc + delay;
            end
        end else if (cyc == b_due) begin
            nb = m_amp_l;
            b_due = -1;
        end
        m_acc_a = na;
        m_acc_b = nb;
        m_fired = fired;
        exp_busy = (m_acc_a != 0) || (m_acc_b != 0) || (b_due != -1);
    endtask

    task automatic m_reset();
        running = 0; b_due = -1; m_acc_a = 0; m_acc_b = 0; m_amp_l = 0;
        m_fired = 0; exp_out = 0; exp_trig = 0; exp_busy = 0;
    endtask

    // Compare process: advance the model on every rising edge, check just after.
    initial begin : compare
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) m_reset();
            else m_step();
            #1;
            chk("model_out", output_data, exp_out);
            chk("model_trig", trigger, exp_trig);
            chk("model_busy", busy, exp_busy);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_trig(input string name, input int maxc, output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < maxc) begin
            @(negedge clk);
            n++;
            if (trigger === 1'b1) found = 1;
        end
        chk({name, "_seen"}, found, 1);
    endtask

    task automatic wait_quiet(input string name);
        bit done;
        int n;
        enable = 1'b0;
        done = 0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) done = 1;
        end
        chk({name, "_quiet"}, done, 1);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        int mx;
        int tc;
        int vals[4];
        reset = 1'b0; enable = 1'b0; overlay = 1'b0; period = 50; delay = 0;
        amplitude = 1600; baseline = 100;
        repeat (3) @(negedge clk);
        chk("rst_out", output_data, 0);
        chk("rst_trig", trigger, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_baseline", output_data, 100);

        // Single pulse train, no overlay.
        enable = 1'b1;
        wait_trig("t1", 10, n);
        chk("t1_latency", n, 3);
        chk("t1_peak", output_data, 1700);
        vals = '{1600, 1507, 1420, 0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_tail", output_data, vals[i]);
            chk("t1_tail_trig", trigger, 0);
        end
        wait_trig("t1_next", 60, n);
        chk("t1_period", n + 3, 50);
        chk("t1_peak2", output_data, 1700);

        // Overlay with delay 3.
        wait_quiet("t2");
        overlay = 1'b1; delay = 3; enable = 1'b1;
        wait_trig("t2", 10, n);
        chk("t2_peak", output_data, 1700);
        vals = '{1600, 1507, 3020, 0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_seq", output_data, vals[i]);
        end
        wait_trig("t2_next", 60, n);
        chk("t2_period", n + 3, 50);

        // Saturation: A and B both load 4000 on the same edge.
        wait_quiet("t3");
        amplitude = 4000; overlay = 1'b1; delay = 0; enable = 1'b1;
        wait_trig("t3", 10, n);
        chk("t3_sat_peak", output_data, 4095);
        @(negedge clk);
        chk("t3_sat_hold", output_data, 4095);

        // period = 1: fires every edge.
        wait_quiet("t4");
        period = 1; amplitude = 50; baseline = 0; overlay = 1'b0; enable = 1'b1;
        wait_trig("t4", 10, n);
        chk("t4_first", output_data, 50);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_const", output_data, 50);
            chk("t4_trig", trigger, 1);
        end

        // delay >= period: B never lands.
        wait_quiet("t5");
        period = 50; delay = 60; overlay = 1'b1; amplitude = 1600; baseline = 100;
        enable = 1'b1;
        wait_trig("t5", 10, n);
        mx = 0; tc = 0;
        for (int i = 0; i < 150; i++) begin
            if (i > 0) @(negedge clk);
            if (int'(output_data) > mx) mx = int'(output_data);
            if (trigger === 1'b1) tc++;
        end
        chk("t5_max", mx, 1700);
        chk("t5_trigs", tc, 3);

        // Asynchronous reset mid-pulse.
        overlay = 1'b0;
        wait_trig("t6", 60, n);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t6_async_out", output_data, 0);
        chk("t6_async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_first_after", output_data, 100);
        wait_trig("t6_restart", 10, n);
        chk("t6_latency", n + 1, 3);
        chk("t6_peak", output_data, 1700);

        // Disable mid-tail: decays to baseline, no new trigger.
        repeat (5) @(negedge clk);
        enable = 1'b0;
        tc = 0; n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            if (trigger === 1'b1) tc++;
        end
        chk("t7_busy_fell", busy, 0);
        chk("t7_no_trig", tc, 0);
        @(negedge clk);
        chk("t7_baseline", output_data, 100);

        // Randomized run, checked by the compare process.
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 7) == 0) enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0)
                period = ($urandom_range(0, 15) == 0) ? 16'd0 : PERIOD_W'($urandom_range(1, 20));
            if ($urandom_range(0, 7) == 0) delay = DELAY_W'($urandom_range(0, 25));
            if ($urandom_range(0, 7) == 0) overlay = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 7) == 0) amplitude = DATA_W'($urandom_range(0, FULL));
            if ($urandom_range(0, 15) == 0) baseline = DATA_W'($urandom_range(0, FULL));
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
